// File: rtl/stopwatch_logic.sv
// Run/stop stopwatch core: mm:ss.hh live count from a 100 Hz clock, with a
// lap-hold display register and a sticky overflow flag.
module stopwatch_logic #(
  parameter int MAX_MINS = 99
) (
  input  logic       CLK_100Hz,
  input  logic       reset_n,
  input  logic       start_stop,
  input  logic       hold,
  output logic [6:0] stopwatch_unit_mins,
  output logic [5:0] stopwatch_unit_secs,
  output logic [6:0] stopwatch_unit_decs,
  output logic       stopwatch_overflow
);

  localparam logic [6:0] MINS_TOP = 7'(MAX_MINS);

  logic [6:0] decs_q, decs_d;
  logic [5:0] secs_q, secs_d;
  logic [6:0] mins_q, mins_d;
  logic       ovf_q, ovf_d;

  logic [6:0] disp_decs_q, disp_decs_d;
  logic [5:0] disp_secs_q, disp_secs_d;
  logic [6:0] disp_mins_q, disp_mins_d;

  // Live count: ripple carry hundredths -> seconds -> minutes -> wrap.
  always_comb begin
    decs_d = decs_q;
    secs_d = secs_q;
    mins_d = mins_q;
    ovf_d  = ovf_q;
    if (start_stop) begin
      if (decs_q == 7'd99) begin
        decs_d = 7'd0;
        if (secs_q == 6'd59) begin
          secs_d = 6'd0;
          if (mins_q == MINS_TOP) begin
            mins_d = 7'd0;
            ovf_d  = 1'b1;
          end else begin
            mins_d = mins_q + 7'd1;
          end
        end else begin
          secs_d = secs_q + 6'd1;
        end
      end else begin
        decs_d = decs_q + 7'd1;
      end
    end
  end

  // Display loads the live count's next value so it shows zero lag when not held.
  always_comb begin
    disp_decs_d = disp_decs_q;
    disp_secs_d = disp_secs_q;
    disp_mins_d = disp_mins_q;
    if (!hold) begin
      disp_decs_d = decs_d;
      disp_secs_d = secs_d;
      disp_mins_d = mins_d;
    end
  end

  // reset_n is active-high despite its name.
  always_ff @(posedge CLK_100Hz or posedge reset_n) begin
    if (reset_n) begin
      decs_q      <= 7'd0;
      secs_q      <= 6'd0;
      mins_q      <= 7'd0;
      ovf_q       <= 1'b0;
      disp_decs_q <= 7'd0;
      disp_secs_q <= 6'd0;
      disp_mins_q <= 7'd0;
    end else begin
      decs_q      <= decs_d;
      secs_q      <= secs_d;
      mins_q      <= mins_d;
      ovf_q       <= ovf_d;
      disp_decs_q <= disp_decs_d;
      disp_secs_q <= disp_secs_d;
      disp_mins_q <= disp_mins_d;
    end
  end

  assign stopwatch_unit_mins = disp_mins_q;
  assign stopwatch_unit_secs = disp_secs_q;
  assign stopwatch_unit_decs = disp_decs_q;
  assign stopwatch_overflow  = ovf_q;

endmodule

// File: tb/tb_stopwatch_logic.sv
// Bench for stopwatch_logic: total-hundredths reference model compared every
// cycle, plus directed literal checkpoints. Small MAX_MINS keeps overflow short.
module tb_stopwatch_logic;

  localparam int TB_MAX = 2;
  localparam int LIMIT  = (TB_MAX + 1) * 6000;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_stop;
  logic       hold;
  logic [6:0] mins;
  logic [5:0] secs;
  logic [6:0] decs;
  logic       ovf;

  int n_checks = 0;
  int n_fail   = 0;

  stopwatch_logic #(.MAX_MINS(TB_MAX)) dut (
    .CLK_100Hz          (clk),
    .reset_n            (rst),
    .start_stop         (start_stop),
    .hold               (hold),
    .stopwatch_unit_mins(mins),
    .stopwatch_unit_secs(secs),
    .stopwatch_unit_decs(decs),
    .stopwatch_overflow (ovf)
  );

  always #5 clk = ~clk;

  // Reference model: elapsed time as one integer count of hundredths.
  int m_total;
  int m_disp;
  bit m_ovf;

  function automatic int next_total(input int t, input logic run);
    int n;
    n = t + (run ? 1 : 0);
    if (n >= LIMIT) n = 0;
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_total <= 0;
      m_disp  <= 0;
      m_ovf   <= 1'b0;
    end else begin
      m_total <= next_total(m_total, start_stop);
      if (!hold) m_disp <= next_total(m_total, start_stop);
      if (start_stop && m_total == LIMIT - 1) m_ovf <= 1'b1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison, sampled well after the edge and away from reset changes.
  always @(posedge clk) begin
    #2;
    chk("model_mins", int'(mins), m_disp / 6000);
    chk("model_secs", int'(secs), (m_disp / 100) % 60);
    chk("model_decs", int'(decs), m_disp % 100);
    chk("model_ovf",  int'(ovf),  int'(m_ovf));
  end

  task automatic lit(input string name, input int em, input int es, input int ed, input int eo);
    chk({name, "_mins"}, int'(mins), em);
    chk({name, "_secs"}, int'(secs), es);
    chk({name, "_decs"}, int'(decs), ed);
    chk({name, "_ovf"},  int'(ovf),  eo);
  endtask

  // Called at a negedge; applies inputs for n rising edges, returns at a negedge.
  task automatic run(input int n, input logic ss, input logic h);
    start_stop = ss;
    hold       = h;
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic ss, input logic h);
    start_stop = ss;
    hold       = h;
    rst        = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst        = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    start_stop = 1'b1;
    hold       = 1'b1;
    @(negedge clk);
    @(negedge clk);
    lit("reset", 0, 0, 0, 0);
    rst = 1'b0;

    run(150, 1'b1, 1'b0);
    lit("run150", 0, 1, 50, 0);

    do_reset(1'b1, 1'b0);
    run(6000, 1'b1, 1'b0);
    lit("run6000", 1, 0, 0, 0);
    run(50, 1'b0, 1'b0);
    lit("stopped", 1, 0, 0, 0);
    run(1, 1'b1, 1'b0);
    lit("resume", 1, 0, 1, 0);

    do_reset(1'b1, 1'b0);
    run(500, 1'b1, 1'b0);
    lit("at5s", 0, 5, 0, 0);
    run(200, 1'b1, 1'b1);
    lit("held", 0, 5, 0, 0);
    run(1, 1'b1, 1'b0);
    lit("unhold", 0, 7, 1, 0);

    do_reset(1'b1, 1'b0);
    run(TB_MAX * 6000 + 5999, 1'b1, 1'b0);
    lit("top", TB_MAX, 59, 99, 0);
    run(1, 1'b1, 1'b0);
    lit("wrap", 0, 0, 0, 1);
    run(1, 1'b1, 1'b0);
    lit("postwrap", 0, 0, 1, 1);

    // Asynchronous reset in mid-cycle, overflow still set from the wrap.
    run(300, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 lit("async_rst", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    run(1, 1'b1, 1'b0);
    lit("after_rst", 0, 0, 1, 0);

    do_reset(1'b1, 1'b1);
    run(6000, 1'b1, 1'b1);
    lit("hold_from_rst", 0, 0, 0, 0);
    run(1, 1'b1, 1'b0);
    lit("hold_drop", 1, 0, 1, 0);

    run(2, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_logic.md
Name: stopwatch_logic

Overview:
- Run/stop stopwatch core counting hundredths of a second, seconds and minutes from a 100 Hz tick clock; one clock edge = 0.01 s.
- Provides a lap/split hold that freezes the displayed time while counting continues, plus a sticky overflow flag.
- Sits between the 100 Hz clock divider and the seven-segment/BCD display formatting logic.

Parameters:
- MAX_MINS, 99, highest minute value before overflow; legal range 1..127.

Ports:
- CLK_100Hz  input  1  100 Hz clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-high reset; asserted when 1 despite the suffix. Clears all state immediately.
- start_stop  input  1  level control; 1 = run, 0 = stopped (count frozen).
- hold  input  1  level control; 1 = displayed outputs frozen (lap hold), 0 = outputs track live count.
- stopwatch_unit_mins  output  7  displayed minutes, 0..MAX_MINS, binary.
- stopwatch_unit_secs  output  6  displayed seconds, 0..59, binary.
- stopwatch_unit_decs  output  7  displayed hundredths, 0..99, binary.
- stopwatch_overflow  output  1  sticky flag; set on wrap past MAX_MINS:59.99.

Behaviour:
- Reset (reset_n=1, asynchronous): live count = 00:00.00, displayed outputs = 0, stopwatch_overflow = 0. These values hold while reset is asserted, regardless of start_stop and hold.
- Live counter, on each rising edge with start_stop=1:
  - decs increments by 1.
  - At 99, decs wraps to 0 and secs increments.
  - At 59, secs wraps to 0 and mins increments.
- With start_stop=0 the live count holds its value. There is no auto-clear on stop.
- Overflow: an increment when the count is MAX_MINS:59.99 wraps the count to 00:00.00 and sets stopwatch_overflow on that same edge. Counting continues after the wrap.
  - stopwatch_overflow stays 1 until reset.
  - stopwatch_overflow always reflects live state and is not frozen by hold.
- Display registers update on each rising edge:
  - hold=0: outputs load the live count's next value, so after the edge the outputs equal the live count (zero-cycle lag).
  - hold=1: outputs retain their previous value; the live count keeps running per start_stop.
  - hold 1->0: outputs show the current live count after the next edge, jumping to it.
- hold=1 at reset release: outputs stay 00:00.00 until hold goes low.
- start_stop and hold are independent; both are sampled only at the rising edge. No edge detection, debouncing or synchronisation is done here.
- Mid-operation reset: counting restarts from 00:00.00 on the first edge after release when start_stop=1.
- Outputs never exceed their stated ranges. Unused codes (decs>99, secs>59) are unreachable.
- Fully synchronous apart from the reset; no combinational path from inputs to outputs.

Test Plan:
- Reset, then start_stop=1, hold=0 for 150 edges -> outputs 000:01.50, overflow 0.
- Run 6000 edges, then start_stop=0 for 50 edges -> outputs stay 001:00.00. start_stop=1 for 1 more edge -> 001:00.01.
- Run to 00:05.00, set hold=1 for 200 edges -> outputs stay 000:05.00. Release hold=0, then 1 edge -> outputs 000:07.01.
- Run continuously from reset with MAX_MINS=99:
  - edge 599999 -> 099:59.99, overflow 0.
  - edge 600000 -> 000:00.00, overflow 1.
  - edge 600001 -> 000:00.01, overflow still 1.
- Assert reset_n=1 mid-count, away from a clock edge -> outputs and overflow go to 0 immediately. Release with start_stop=1 -> first edge gives 000:00.01.
- Hold 1 from reset with start_stop=1 for 6000 edges -> outputs 000:00.00. Drop hold, then 1 edge -> 001:00.01.
